// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the 24-bit datapath: runs a req/ack handshake to data
// memory, holds load data for the writeback mux and stalls the core meanwhile.
module mem_access_ctrl #(
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              we,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata_q,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cap_en;
   logic             ld_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // An ack in the last allowed wait cycle is checked first, so it completes
   // the access instead of aborting it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap_en    = 1'b0;
      ld_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = REQ;
               cnt_nxt   = '0;
               cap_en    = 1'b1;
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_nxt = DONE;
               ld_en     = ~mem_we;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are frozen at start so memory sees them stable for the whole wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         if (cap_en) begin
            mem_we    <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
         end
         if (ld_en) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_req = (state == REQ);
   assign busy    = (state == REQ);
   assign done    = (state == DONE);
   assign err     = (state == ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of accesses with a scoreboard of expected
// completions, plus hand sequences for start-while-busy and reset mid-request.
module tb_mem_access_ctrl;

   localparam int DATA_W = 24;

   logic              clk = 1'b0;
   logic              reset, start, we, mem_ack;
   logic [DATA_W-1:0] addr, wdata, mem_rdata;
   logic              mem_req, mem_we, busy, done, err;
   logic [DATA_W-1:0] mem_addr, mem_wdata, rdata_q;

   mem_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT(15), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .we(we), .addr(addr), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata_q(rdata_q),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [23:0] wdata;
      logic [23:0] rdata;
      int          delay;      // REQ cycle index carrying the ack; >=15 means never
      logic        exp_done;
      logic        exp_err;
      logic [23:0] exp_rdq;
      int          exp_cycles; // cycles with mem_req high
   } vec_t;

   vec_t tbl[8];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic run_vec(input vec_t v);
      vec_t e;
      int   waited, reqc;
      bit   fin;
      sb.push_back(v);
      start = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      start = 1'b0; we = ~v.we; addr = ~v.addr; wdata = ~v.wdata;
      waited = 0; reqc = 0; fin = 0;
      while (!fin && waited < 40) begin
         if (done || err) begin
            fin = 1;
         end else begin
            reqc++;
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("mem_addr", {8'd0, mem_addr}, {8'd0, v.addr});
            chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
            chk("mem_wdata", {8'd0, mem_wdata}, {8'd0, v.wdata});
            mem_ack   = (waited == v.delay);
            mem_rdata = mem_ack ? v.rdata : (v.rdata ^ 24'h0F0F0F);
            @(negedge clk);
            mem_ack = 1'b0;
            waited++;
         end
      end
      if (!fin) chk("completion_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("done", {31'd0, done}, {31'd0, e.exp_done});
         chk("err", {31'd0, err}, {31'd0, e.exp_err});
         chk("rdata_q", {8'd0, rdata_q}, {8'd0, e.exp_rdq});
         chk("busy_end", {31'd0, busy}, 32'd0);
         chk("req_cycles", reqc, e.exp_cycles);
         // ack during DONE/ERR must be ignored
         mem_ack = 1'b1; mem_rdata = 24'h777777;
         @(negedge clk);
         mem_ack = 1'b0;
         chk("pulse_done", {31'd0, done}, 32'd0);
         chk("pulse_err", {31'd0, err}, 32'd0);
         chk("idle_req", {31'd0, mem_req}, 32'd0);
         chk("rdata_hold", {8'd0, rdata_q}, {8'd0, e.exp_rdq});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      vec_t fresh;
      tbl[0] = '{1'b0, 24'h000010, 24'h000000, 24'hABCDEF, 0,   1'b1, 1'b0, 24'hABCDEF, 1};
      tbl[1] = '{1'b1, 24'h0000FF, 24'h123456, 24'hBAD000, 3,   1'b1, 1'b0, 24'hABCDEF, 4};
      tbl[2] = '{1'b0, 24'h000020, 24'h000000, 24'h999999, 255, 1'b0, 1'b1, 24'hABCDEF, 15};
      tbl[3] = '{1'b0, 24'h000030, 24'h000000, 24'h5A5A5A, 14,  1'b1, 1'b0, 24'h5A5A5A, 15};
      tbl[4] = '{1'b0, 24'hFFFFFF, 24'h000000, 24'h000000, 13,  1'b1, 1'b0, 24'h000000, 14};
      tbl[5] = '{1'b1, 24'h000000, 24'hFFFFFF, 24'hBAD111, 1,   1'b1, 1'b0, 24'h000000, 2};
      tbl[6] = '{1'b1, 24'h00ABCD, 24'h654321, 24'hBAD222, 255, 1'b0, 1'b1, 24'h000000, 15};
      tbl[7] = '{1'b0, 24'h800000, 24'h000000, 24'h800001, 2,   1'b1, 1'b0, 24'h800001, 3};

      reset = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
      chk("rst_mem_fields", {7'd0, mem_we, mem_addr}, 32'd0);
      chk("rst_wdata_rdq", {8'd0, mem_wdata | rdata_q}, 32'd0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // start while busy: second start ignored, one done only
      start = 1'b1; we = 1'b0; addr = 24'h000040; wdata = '0;
      @(negedge clk);
      start = 1'b1; addr = 24'h000050;
      chk("busy_addr0", {8'd0, mem_addr}, 32'h000040);
      @(negedge clk);
      start = 1'b0;
      chk("busy_addr1", {8'd0, mem_addr}, 32'h000040);
      chk("busy_req1", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 24'h111111;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("busy_done", {31'd0, done}, 32'd1);
      chk("busy_rdq", {8'd0, rdata_q}, 32'h111111);
      start = 1'b1; addr = 24'h000060;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", {30'd0, busy, mem_req}, 32'd0);
      ndone = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("single_done", ndone, 0);
      chk("busy_addr_kept", {8'd0, mem_addr}, 32'h000040);

      // reset during the wait
      start = 1'b1; we = 1'b0; addr = 24'h000070;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mid_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_req_busy", {30'd0, mem_req, busy}, 32'd0);
      chk("mid_rst_rdq", {8'd0, rdata_q}, 32'd0);
      chk("mid_rst_addr", {8'd0, mem_addr}, 32'd0);
      chk("mid_rst_pulses", {30'd0, done, err}, 32'd0);
      @(negedge clk);
      chk("mid_rst_idle", {31'd0, busy}, 32'd0);

      fresh = '{1'b0, 24'h000123, 24'h000000, 24'hC0FFEE, 1, 1'b1, 1'b0, 24'hC0FFEE, 2};
      run_vec(fresh);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
